// File: rtl/host_frame_receiver_pkg.sv
// Shared definitions for the host command frame format.
// The downstream transmitter framer builds its frames from these same constants.
package host_frame_receiver_pkg;

    // Receiver parse states.
    typedef enum logic [2:0] {
        StHunt,
        StCtrl,
        StData,
        StCheck,
        StDeliver,
        StHold
    } rxState_t;

    localparam int unsigned FRAME_DATA_BYTES = 4;
    localparam int unsigned FRAME_IDX_W      = $clog2(FRAME_DATA_BYTES);

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Byte positions within a frame: SYNC, control, data MSB..LSB, checksum.
    localparam int unsigned FRAME_POS_SYNC = 0;
    localparam int unsigned FRAME_POS_CTRL = 1;
    localparam int unsigned FRAME_POS_DATA = 2;
    localparam int unsigned FRAME_POS_CHK  = FRAME_POS_DATA + FRAME_DATA_BYTES;
    localparam int unsigned FRAME_LEN      = FRAME_POS_CHK + 1;

    // Checksum is the XOR of control and all data bytes; SYNC is excluded.
    function automatic logic [7:0] frameChecksum(input logic [7:0]  ctrl,
                                                 input logic [31:0] data);
        return ctrl ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
    endfunction

endpackage

// File: rtl/host_frame_receiver_rx_timeout_timer.sv
// Inter-byte idle timer for a frame in progress.
// expired is a single-cycle pulse; a kick in the same cycle suppresses it.
module rx_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic masterClock,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expiry fires only while armed and with no byte arriving this cycle.
    always_comb begin
        expired = enable && !kick && (count_q == LAST_COUNT);
    end

    // Count idle cycles; restart on any byte, when disarmed, or after expiry.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (!enable || kick || expired) begin
            count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/host_frame_receiver.sv
// Parses the UART host byte stream into command frames and hands each valid
// frame to the process with a dataReceived / clearDR handshake.
// Bad checksums, inter-byte timeouts and overruns are dropped and counted.
module host_frame_receiver
    import host_frame_receiver_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                 masterClock,
    input  logic                 reset,
    input  logic                 rxValid,
    input  logic [7:0]           rxByte,
    input  logic                 clearDR,
    output logic                 dataReceived,
    output logic [7:0]           control,
    output logic [31:0]          inputData,
    output logic                 frameError,
    output logic [ERR_CNT_W-1:0] chkErrCount,
    output logic [ERR_CNT_W-1:0] timeoutCount,
    output logic [ERR_CNT_W-1:0] overrunCount
);

    rxState_t               state_q, state_d;
    logic [7:0]             ctrlShadow_q, ctrlShadow_d;
    logic [31:0]            dataShadow_q, dataShadow_d;
    logic [7:0]             chk_q, chk_d;
    logic [FRAME_IDX_W-1:0] idx_q, idx_d;

    logic                   dataReceived_q, dataReceived_d;
    logic [7:0]             control_q, control_d;
    logic [31:0]            inputData_q, inputData_d;
    logic                   frameError_q, frameError_d;
    logic [ERR_CNT_W-1:0]   chkErrCount_q, chkErrCount_d;
    logic [ERR_CNT_W-1:0]   timeoutCount_q, timeoutCount_d;
    logic [ERR_CNT_W-1:0]   overrunCount_q, overrunCount_d;

    logic                   timerEnable;
    logic                   timerExpired;
    logic                   incChk, incTimeout, incOverrun;

    // Timer is armed only while a frame is partially received.
    always_comb begin
        timerEnable = (state_q == StCtrl) || (state_q == StData) || (state_q == StCheck);
    end

    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx_timeout_timer (
        .masterClock(masterClock),
        .reset      (reset),
        .enable     (timerEnable),
        .kick       (rxValid),
        .expired    (timerExpired)
    );

    // Frame parser next-state and error classification.
    always_comb begin
        state_d        = state_q;
        ctrlShadow_d   = ctrlShadow_q;
        dataShadow_d   = dataShadow_q;
        chk_d          = chk_q;
        idx_d          = idx_q;
        dataReceived_d = dataReceived_q;
        control_d      = control_q;
        inputData_d    = inputData_q;
        incChk         = 1'b0;
        incTimeout     = 1'b0;
        incOverrun     = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (rxValid && (rxByte == SYNC_BYTE)) begin
                    state_d      = StCtrl;
                    chk_d        = '0;
                    ctrlShadow_d = '0;
                    dataShadow_d = '0;
                end
            end
            StCtrl: begin
                if (rxValid) begin
                    ctrlShadow_d = rxByte;
                    chk_d        = rxByte;
                    idx_d        = '0;
                    state_d      = StData;
                end else if (timerExpired) begin
                    incTimeout = 1'b1;
                    state_d    = StHunt;
                end
            end
            StData: begin
                if (rxValid) begin
                    dataShadow_d = {dataShadow_q[23:0], rxByte};
                    chk_d        = chk_q ^ rxByte;
                    idx_d        = idx_q + FRAME_IDX_W'(1);
                    if (idx_q == FRAME_IDX_W'(FRAME_DATA_BYTES - 1)) begin
                        state_d = StCheck;
                    end
                end else if (timerExpired) begin
                    incTimeout = 1'b1;
                    state_d    = StHunt;
                end
            end
            StCheck: begin
                if (rxValid) begin
                    if (rxByte == chk_q) begin
                        control_d   = ctrlShadow_q;
                        inputData_d = dataShadow_q;
                        state_d     = StDeliver;
                    end else begin
                        incChk  = 1'b1;
                        state_d = StHunt;
                    end
                end else if (timerExpired) begin
                    incTimeout = 1'b1;
                    state_d    = StHunt;
                end
            end
            StDeliver: begin
                incOverrun = rxValid;
                // Wait for the process to release its previous clear first.
                if (!clearDR) begin
                    dataReceived_d = 1'b1;
                    state_d        = StHold;
                end
            end
            StHold: begin
                incOverrun = rxValid;
                if (clearDR) begin
                    dataReceived_d = 1'b0;
                    state_d        = StHunt;
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase
    end

    // Saturating error counters and the shared error pulse.
    always_comb begin
        chkErrCount_d  = chkErrCount_q;
        timeoutCount_d = timeoutCount_q;
        overrunCount_d = overrunCount_q;
        frameError_d   = incChk || incTimeout || incOverrun;
        if (incChk && (chkErrCount_q != '1)) begin
            chkErrCount_d = chkErrCount_q + ERR_CNT_W'(1);
        end
        if (incTimeout && (timeoutCount_q != '1)) begin
            timeoutCount_d = timeoutCount_q + ERR_CNT_W'(1);
        end
        if (incOverrun && (overrunCount_q != '1)) begin
            overrunCount_d = overrunCount_q + ERR_CNT_W'(1);
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            state_q        <= StHunt;
            ctrlShadow_q   <= '0;
            dataShadow_q   <= '0;
            chk_q          <= '0;
            idx_q          <= '0;
            dataReceived_q <= 1'b0;
            control_q      <= '0;
            inputData_q    <= '0;
            frameError_q   <= 1'b0;
            chkErrCount_q  <= '0;
            timeoutCount_q <= '0;
            overrunCount_q <= '0;
        end else begin
            state_q        <= state_d;
            ctrlShadow_q   <= ctrlShadow_d;
            dataShadow_q   <= dataShadow_d;
            chk_q          <= chk_d;
            idx_q          <= idx_d;
            dataReceived_q <= dataReceived_d;
            control_q      <= control_d;
            inputData_q    <= inputData_d;
            frameError_q   <= frameError_d;
            chkErrCount_q  <= chkErrCount_d;
            timeoutCount_q <= timeoutCount_d;
            overrunCount_q <= overrunCount_d;
        end
    end

    assign dataReceived = dataReceived_q;
    assign control      = control_q;
    assign inputData    = inputData_q;
    assign frameError   = frameError_q;
    assign chkErrCount  = chkErrCount_q;
    assign timeoutCount = timeoutCount_q;
    assign overrunCount = overrunCount_q;

endmodule

// File: tb/tb_host_frame_receiver.sv
// Directed bench for host_frame_receiver with a short inter-byte timeout.
module tb_host_frame_receiver;

    localparam int unsigned TIMEOUT = 16;

    logic        masterClock = 1'b0;
    logic        reset;
    logic        rxValid;
    logic [7:0]  rxByte;
    logic        clearDR;
    logic        dataReceived;
    logic [7:0]  control;
    logic [31:0] inputData;
    logic        frameError;
    logic [7:0]  chkErrCount;
    logic [7:0]  timeoutCount;
    logic [7:0]  overrunCount;

    int nChecks = 0;
    int nErrors = 0;
    int feCount = 0;

    host_frame_receiver #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TIMEOUT),
        .ERR_CNT_W     (8)
    ) dut (
        .masterClock (masterClock),
        .reset       (reset),
        .rxValid     (rxValid),
        .rxByte      (rxByte),
        .clearDR     (clearDR),
        .dataReceived(dataReceived),
        .control     (control),
        .inputData   (inputData),
        .frameError  (frameError),
        .chkErrCount (chkErrCount),
        .timeoutCount(timeoutCount),
        .overrunCount(overrunCount)
    );

    always #5 masterClock = ~masterClock;

    // Count frameError pulses, sampled mid-cycle.
    always @(negedge masterClock) begin
        if (frameError === 1'b1) feCount++;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge masterClock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sendByte(input logic [7:0] b);
        rxValid = 1'b1;
        rxByte  = b;
        tick();
        rxValid = 1'b0;
        rxByte  = 8'h00;
    endtask

    task automatic sendFrame(input logic [7:0] c, input logic [31:0] d, input logic [7:0] k);
        sendByte(8'hA5);
        sendByte(c);
        sendByte(d[31:24]);
        sendByte(d[23:16]);
        sendByte(d[15:8]);
        sendByte(d[7:0]);
        sendByte(k);
    endtask

    initial begin
        reset   = 1'b1;
        rxValid = 1'b0;
        rxByte  = 8'h00;
        clearDR = 1'b0;
        #3 reset = 1'b0;
        idle(3);

        // Reset state
        check("rst_dr", 32'(dataReceived), 32'd0);
        check("rst_ctrl", 32'(control), 32'd0);
        check("rst_data", inputData, 32'd0);
        check("rst_fe", 32'(frameError), 32'd0);
        check("rst_chkcnt", 32'(chkErrCount), 32'd0);
        check("rst_tocnt", 32'(timeoutCount), 32'd0);
        check("rst_ovcnt", 32'(overrunCount), 32'd0);
        reset = 1'b1;
        tick();

        // Valid frame, two-cycle latency, clear handshake
        sendFrame(8'h01, 32'h12345678, 8'h09);
        check("lat_dr_low", 32'(dataReceived), 32'd0);
        check("v1_ctrl", 32'(control), 32'h01);
        tick();
        check("v1_dr", 32'(dataReceived), 32'd1);
        check("v1_data", inputData, 32'h12345678);
        check("v1_fe", 32'(feCount), 32'd0);
        clearDR = 1'b1;
        tick();
        check("v1_clear", 32'(dataReceived), 32'd0);
        clearDR = 1'b0;
        tick();

        // Bad checksum, then a good frame
        sendFrame(8'h01, 32'h12345678, 8'h08);
        check("bad_fe_pulse", 32'(frameError), 32'd1);
        check("bad_chkcnt", 32'(chkErrCount), 32'd1);
        tick();
        check("bad_fe_single", 32'(frameError), 32'd0);
        check("bad_fe_cnt", 32'(feCount), 32'd1);
        check("bad_dr", 32'(dataReceived), 32'd0);
        sendFrame(8'h02, 32'hAABBCCDD, 8'h02);
        tick();
        check("v2_dr", 32'(dataReceived), 32'd1);
        check("v2_ctrl", 32'(control), 32'h02);
        check("v2_data", inputData, 32'hAABBCCDD);
        clearDR = 1'b1;
        tick();
        clearDR = 1'b0;
        tick();

        // Inter-byte timeout
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h12);
        idle(15);
        check("to_not_yet", 32'(timeoutCount), 32'd0);
        tick();
        check("to_cnt", 32'(timeoutCount), 32'd1);
        check("to_fe_pulse", 32'(frameError), 32'd1);
        tick();
        check("to_fe_cnt", 32'(feCount), 32'd2);
        sendByte(8'h34);
        sendByte(8'h56);
        tick();
        check("to_tail_dr", 32'(dataReceived), 32'd0);
        check("to_tail_fe", 32'(feCount), 32'd2);
        // Byte arriving on the expiry cycle wins
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h12);
        idle(15);
        sendByte(8'h34);
        check("to_edge_cnt", 32'(timeoutCount), 32'd1);
        sendByte(8'h56);
        sendByte(8'h78);
        sendByte(8'h09);
        tick();
        check("to_edge_dr", 32'(dataReceived), 32'd1);
        check("to_edge_data", inputData, 32'h12345678);

        // Overrun while holding
        sendByte(8'hA5);
        sendByte(8'h11);
        sendByte(8'h22);
        tick();
        check("ov_cnt", 32'(overrunCount), 32'd3);
        check("ov_fe_cnt", 32'(feCount), 32'd5);
        check("ov_dr", 32'(dataReceived), 32'd1);
        check("ov_ctrl", 32'(control), 32'h01);
        check("ov_data", inputData, 32'h12345678);
        clearDR = 1'b1;
        tick();
        check("ov_clear", 32'(dataReceived), 32'd0);
        clearDR = 1'b0;
        tick();

        // Frame completes while clearDR is still high
        clearDR = 1'b1;
        sendFrame(8'h03, 32'h01020304, 8'h07);
        idle(3);
        check("cd_wait_dr", 32'(dataReceived), 32'd0);
        check("cd_ctrl", 32'(control), 32'h03);
        clearDR = 1'b0;
        tick();
        check("cd_dr_rise", 32'(dataReceived), 32'd1);
        clearDR = 1'b1;
        tick();
        clearDR = 1'b0;
        tick();

        // Garbage before SYNC is ignored silently
        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'hA4);
        sendFrame(8'h04, 32'hDEADBEEF, 8'h26);
        tick();
        check("gb_dr", 32'(dataReceived), 32'd1);
        check("gb_data", inputData, 32'hDEADBEEF);
        check("gb_fe_cnt", 32'(feCount), 32'd5);

        // Asynchronous reset while holding a frame
        @(posedge masterClock);
        #3 reset = 1'b0;
        #1;
        check("ar_dr", 32'(dataReceived), 32'd0);
        check("ar_ctrl", 32'(control), 32'd0);
        check("ar_data", inputData, 32'd0);
        check("ar_chkcnt", 32'(chkErrCount), 32'd0);
        check("ar_tocnt", 32'(timeoutCount), 32'd0);
        check("ar_ovcnt", 32'(overrunCount), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Reset mid-DATA discards the partial frame
        sendByte(8'hA5);
        sendByte(8'h05);
        sendByte(8'h11);
        sendByte(8'h22);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        sendByte(8'h33);
        sendByte(8'h44);
        sendByte(8'h41);
        tick();
        check("rd_dr", 32'(dataReceived), 32'd0);
        check("rd_ctrl", 32'(control), 32'd0);
        check("rd_fe_cnt", 32'(feCount), 32'd5);
        sendFrame(8'h01, 32'h12345678, 8'h09);
        tick();
        check("rd_after_dr", 32'(dataReceived), 32'd1);
        check("rd_after_ctrl", 32'(control), 32'h01);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
